child_rr_arbiter: RTL

CHILD_RR_ARBITER -- requirements
Module: child_rr_arbiter

---
 rtl/child_rr_arbiter_pkg.sv | 13 +
 rtl/child_rr_arbiter_rr_pick.sv | 27 ++
 rtl/child_rr_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/child_rr_arbiter_pkg.sv
// rtl/child_rr_arbiter_pkg.sv - shared state enum and default constants for child_rr_arbiter
package child_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_t;

   localparam int N_REQ_DEF    = 5;
   localparam int MAX_HOLD_DEF = 15;

endpackage

// File: rtl/child_rr_arbiter_rr_pick.sv
// rtl/child_rr_arbiter_rr_pick.sv - combinational round-robin picker: first set req bit at or after ptr
module rr_pick #(
   parameter int N = 5
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   ptr,
   output logic [2:0]   winner,
   output logic         valid
);

   int idx;

   // Scan from the farthest candidate back to ptr so the closest hit wins.
   always_comb begin
      winner = 3'd0;
      valid  = 1'b0;
      idx    = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (req[idx]) begin
            winner = 3'(idx);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/child_rr_arbiter.sv
// rtl/child_rr_arbiter.sv - round-robin arbiter with bounded grant tenure and a one-cycle handover gap
module child_rr_arbiter
   import child_rr_arbiter_pkg::*;
#(
   parameter int N_REQ    = N_REQ_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] gnt,
   output logic [2:0]       gnt_id,
   output logic             busy,
   output logic             timeout
);

   localparam int             CW       = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0]  HOLD_MAX = CW'(MAX_HOLD);
   localparam logic [2:0]     LAST_IDX = 3'(N_REQ - 1);

   arb_state_t    state;
   logic [2:0]    ptr;
   logic [CW-1:0] cnt;
   logic [2:0]    win;
   logic          win_vld;
   logic          owner_req;

   rr_pick #(.N(N_REQ)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (win),
      .valid  (win_vld)
   );

   // gnt is one-hot while granted, so masking req with it isolates the owner's bit.
   assign owner_req = |(req & gnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         gnt     <= '0;
         gnt_id  <= 3'd0;
         busy    <= 1'b0;
         timeout <= 1'b0;
         ptr     <= 3'd0;
         cnt     <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  state  <= GRANT;
                  gnt    <= N_REQ'(1) << win;
                  gnt_id <= win;
                  busy   <= 1'b1;
                  cnt    <= CW'(1);
                  ptr    <= (win == LAST_IDX) ? 3'd0 : win + 3'd1;
               end
            end
            GRANT: begin
               if (done || !owner_req || cnt == HOLD_MAX) begin
                  // Only pure expiry reaches here with done low and the owner still requesting.
                  state   <= GAP;
                  gnt     <= '0;
                  busy    <= 1'b0;
                  cnt     <= '0;
                  timeout <= !done && owner_req;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
